// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP register bank.
package sap_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        LOAD = 2'd1,
        INC  = 2'd2,
        DEC  = 2'd3
    } op_e;

    localparam int SAP_WIDTH = 8;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit bank register: clear, load, increment, decrement, plus zero and wrap detection.
module register_cell
    import sap_pkg::*;
#(
    parameter int WIDTH = SAP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  op_e              op,
    input  logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             wrap_evt
);

    // NOTE: sequential state uses non-blocking assignments so every cell samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (en) begin
            if (clr) begin
                value <= '0;
            end else begin
                case (op)
                    LOAD:    value <= bus;
                    INC:     value <= value + WIDTH'(1);
                    DEC:     value <= value - WIDTH'(1);
                    default: value <= value;
                endcase
            end
        end
    end

    assign zero = (value == '0);

    // A clear takes priority over the operation, so it can never report a wrap.
    assign wrap_evt = en && !clr &&
                      (((op == INC) && (value == '1)) ||
                       ((op == DEC) && (value == '0)));

endmodule

// File: rtl/register_bank.sv
// Bank of DEPTH bus registers with address decode, tri-state bus drive and a sticky wrap flag.
module register_bank
    import sap_pkg::*;
#(
    parameter int WIDTH  = SAP_WIDTH,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   debug,
    input  op_e                    op,
    input  logic [ADDR_W-1:0]      op_addr,
    input  logic                   clr,
    input  logic [WIDTH-1:0]       bus,
    input  logic                   send,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_oe,
    output logic [DEPTH*WIDTH-1:0] unbuffered_out,
    output logic [DEPTH-1:0]       zero,
    output logic                   wrap,
    input  logic                   wrap_clr
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] wrap_evt;
    logic [WIDTH-1:0] rd_val;

    // Addresses at or beyond DEPTH match no cell, so the operation is silently discarded.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        register_cell #(.WIDTH(WIDTH)) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (op_addr == ADDR_W'(i)),
            .clr      (clr),
            .op       (op),
            .bus      (bus),
            .value    (data[i]),
            .zero     (zero[i]),
            .wrap_evt (wrap_evt[i])
        );
        assign unbuffered_out[i*WIDTH +: WIDTH] = data[i];
    end

    // NOTE: rd_val gets a default before the search loop so no latch is inferred.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_val = data[i];
            end
        end
    end

    assign bus_out = send ? rd_val : {WIDTH{1'bz}};
    assign bus_oe  = send;

    // A wrap in the same cycle as wrap_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else if (|wrap_evt) begin
            wrap <= 1'b1;
        end else if (wrap_clr) begin
            wrap <= 1'b0;
        end
    end

    // debug only steers simulation logging, which is kept outside the synthesizable bank.
    logic unused_debug;
    assign unused_debug = debug;

endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven bench for register_bank (default 8x4 plus a 4-bit x 3 instance).
module tb_register_bank;
    import sap_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance: WIDTH=8, DEPTH=4
    op_e         op;
    logic [1:0]  op_addr, rd_addr;
    logic        clr, send, wrap_clr;
    logic [7:0]  bus, bus_out;
    logic        bus_oe, wrap;
    logic [31:0] unb;
    logic [3:0]  zero;

    register_bank dut (
        .clk(clk), .rst_n(rst_n), .debug(1'b0), .op(op), .op_addr(op_addr),
        .clr(clr), .bus(bus), .send(send), .rd_addr(rd_addr), .bus_out(bus_out),
        .bus_oe(bus_oe), .unbuffered_out(unb), .zero(zero), .wrap(wrap),
        .wrap_clr(wrap_clr)
    );

    // Small instance: WIDTH=4, DEPTH=3 (address 3 is out of range)
    op_e         op2;
    logic [1:0]  op_addr2, rd_addr2;
    logic        clr2, send2, wrap_clr2;
    logic [3:0]  bus2, bus_out2;
    logic        bus_oe2, wrap2;
    logic [11:0] unb2;
    logic [2:0]  zero2;

    register_bank #(.WIDTH(4), .DEPTH(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .debug(1'b0), .op(op2), .op_addr(op_addr2),
        .clr(clr2), .bus(bus2), .send(send2), .rd_addr(rd_addr2), .bus_out(bus_out2),
        .bus_oe(bus_oe2), .unbuffered_out(unb2), .zero(zero2), .wrap(wrap2),
        .wrap_clr(wrap_clr2)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        op_e         op;
        logic [1:0]  addr;
        logic        clr;
        logic [7:0]  bus;
        logic        wclr;
        logic        send;
        logic [1:0]  rd;
        logic [31:0] e_unb;
        logic [3:0]  e_zero;
        logic        e_wrap;
        logic [7:0]  e_bus;
    } vec_t;

    vec_t vecs [14];

    task automatic drive(input op_e o, input logic [1:0] a, input logic c, input logic [7:0] b,
                         input logic wc, input logic s, input logic [1:0] r);
        op = o; op_addr = a; clr = c; bus = b; wrap_clr = wc; send = s; rd_addr = r;
    endtask

    task automatic drive2(input op_e o, input logic [1:0] a, input logic [3:0] b,
                          input logic s, input logic [1:0] r);
        op2 = o; op_addr2 = a; clr2 = 1'b0; bus2 = b; wrap_clr2 = 1'b0; send2 = s; rd_addr2 = r;
    endtask

    initial begin
        // op, addr, clr, bus, wclr, send, rd, exp unbuffered, exp zero, exp wrap, exp bus_out
        vecs[0]  = '{LOAD, 2'd1, 1'b0, 8'hFE, 1'b0, 1'b1, 2'd1, 32'h00A5FE00, 4'b1001, 1'b0, 8'hFE};
        vecs[1]  = '{INC,  2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 32'h00A5FF00, 4'b1001, 1'b0, 8'hFF};
        vecs[2]  = '{INC,  2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 32'h00A50000, 4'b1011, 1'b1, 8'h00};
        vecs[3]  = '{INC,  2'd1, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 32'h00A50100, 4'b1001, 1'b0, 8'h01};
        vecs[4]  = '{DEC,  2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 32'h00A501FF, 4'b1000, 1'b1, 8'hFF};
        vecs[5]  = '{LOAD, 2'd3, 1'b0, 8'h10, 1'b0, 1'b1, 2'd3, 32'h10A501FF, 4'b0000, 1'b1, 8'h10};
        vecs[6]  = '{INC,  2'd3, 1'b1, 8'h00, 1'b0, 1'b1, 2'd3, 32'h00A501FF, 4'b1000, 1'b1, 8'h00};
        vecs[7]  = '{LOAD, 2'd2, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2, 32'h00A501FF, 4'b1000, 1'b1, 8'hA5};
        vecs[8]  = '{NOP,  2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 32'h00A501FF, 4'b1000, 1'b0, 8'h01};
        vecs[9]  = '{DEC,  2'd1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd1, 32'h00A500FF, 4'b1010, 1'b0, 8'h00};
        vecs[10] = '{DEC,  2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h000000FF, 4'b1110, 1'b0, 8'h00};
        vecs[11] = '{DEC,  2'd1, 1'b1, 8'h00, 1'b0, 1'b1, 2'd1, 32'h000000FF, 4'b1110, 1'b0, 8'h00};
        vecs[12] = '{INC,  2'd0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 32'h00000000, 4'b1111, 1'b1, 8'h00};
        vecs[13] = '{LOAD, 2'd3, 1'b0, 8'h3C, 1'b0, 1'b1, 2'd3, 32'h3C000000, 4'b0111, 1'b1, 8'h3C};

        // Reset state
        rst_n = 1'b0;
        drive(NOP, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
        drive2(NOP, 2'd0, 4'h0, 1'b0, 2'd0);
        #2;
        check("rst_unb", 64'(unb), 64'h0);
        check("rst_zero", 64'(zero), 64'hF);
        check("rst_wrap", 64'(wrap), 64'h0);
        check("rst_oe_off", 64'(bus_oe), 64'h0);
        send = 1'b1;
        #1;
        check("rst_send_bus", 64'(bus_out), 64'h0);
        check("rst_oe_on", 64'(bus_oe), 64'h1);
        send = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD 0xA5 into reg 2 with read-during-write on the same register
        @(negedge clk);
        drive(LOAD, 2'd2, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd2);
        #1;
        check("rdw_old", 64'(bus_out), 64'h00);
        @(posedge clk);
        #1;
        check("rdw_new", 64'(bus_out), 64'hA5);
        check("load_zero", 64'(zero), 64'b1011);

        // Table-driven sequence
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].addr, vecs[i].clr, vecs[i].bus, vecs[i].wclr,
                  vecs[i].send, vecs[i].rd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_unb", i), 64'(unb), 64'(vecs[i].e_unb));
            check($sformatf("v%0d_zero", i), 64'(zero), 64'(vecs[i].e_zero));
            check($sformatf("v%0d_wrap", i), 64'(wrap), 64'(vecs[i].e_wrap));
            check($sformatf("v%0d_oe", i), 64'(bus_oe), 64'(vecs[i].send));
            if (vecs[i].send) begin
                check($sformatf("v%0d_bus", i), 64'(bus_out), 64'(vecs[i].e_bus));
            end
        end

        // Asynchronous reset mid-cycle with a LOAD pending
        @(negedge clk);
        drive(LOAD, 2'd0, 1'b0, 8'h77, 1'b0, 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_unb", 64'(unb), 64'h0);
        check("arst_zero", 64'(zero), 64'hF);
        check("arst_wrap", 64'(wrap), 64'h0);
        @(posedge clk);
        #1;
        check("arst_held", 64'(unb), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_load", 64'(unb), 64'h00000077);
        check("post_rst_zero", 64'(zero), 64'b1110);
        @(negedge clk);
        drive(NOP, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0);

        // WIDTH=4, DEPTH=3 instance
        @(negedge clk);
        drive2(LOAD, 2'd0, 4'hF, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        check("p_load", 64'(unb2), 64'h00F);
        check("p_load_bus", 64'(bus_out2), 64'hF);
        @(negedge clk);
        drive2(LOAD, 2'd3, 4'h5, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check("p_oob_load", 64'(unb2), 64'h00F);
        check("p_oob_zero", 64'(zero2), 64'b110);
        @(negedge clk);
        drive2(INC, 2'd3, 4'h0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        check("p_oob_inc", 64'(unb2), 64'h00F);
        check("p_oob_wrap", 64'(wrap2), 64'h0);
        @(negedge clk);
        drive2(INC, 2'd0, 4'h0, 1'b1, 2'd3);
        @(posedge clk);
        #1;
        check("p_inc_wrap_val", 64'(unb2), 64'h000);
        check("p_inc_wrap", 64'(wrap2), 64'h1);
        check("p_zero_all", 64'(zero2), 64'b111);
        check("p_oob_rd", 64'(bus_out2), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
